// File: rtl/fish_pkg.sv
// Shared types and constants for the fish beam detector.
package fish_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURE   = 2'd1,
        QUALIFIED = 2'd2
    } fish_state_e;

    localparam int unsigned CAL_MIN   = 1;
    localparam int unsigned WIDTH_MAX = 15;
    localparam int unsigned WIDTH_W   = 4;
    localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/fish_tick_gen.sv
// Sample-tick generator: one-cycle pulse every TICK_DIV clocks, first one TICK_DIV cycles after reset.
module fish_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + DIV_W'(1);
            r_tick <= w_wrap;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/fish_detect.sv
// Beam-break fish detector: synchronizes the sensor, qualifies blocked widths in ticks and counts fish.
module fish_detect
    import fish_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor,
    input  logic [3:0]       fish_cal,
    input  logic             clear,
    output logic [CNT_W-1:0] fish_cnt,
    output logic             fish_evt,
    output logic             busy,
    output logic             sat
);

    logic               r_sync1;
    logic               r_sync2;
    fish_state_e        r_state;
    fish_state_e        w_state_nxt;
    logic [WIDTH_W-1:0] r_width;
    logic [WIDTH_W-1:0] w_width_nxt;
    logic [WIDTH_W-1:0] r_cal_lat;
    logic [WIDTH_W-1:0] w_cal_lat_nxt;
    logic [WIDTH_W-1:0] w_cal_sel;
    logic               w_fish;
    logic               w_tick;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_evt;
    logic               r_busy;
    logic               r_sat;

    fish_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end

    // A zero calibration still demands at least one blocked tick.
    assign w_cal_sel = (fish_cal < WIDTH_W'(CAL_MIN)) ? WIDTH_W'(CAL_MIN) : fish_cal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_width   <= '0;
            r_cal_lat <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_width   <= w_width_nxt;
            r_cal_lat <= w_cal_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_width_nxt   = r_width;
        w_cal_lat_nxt = r_cal_lat;
        w_fish        = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        w_width_nxt   = WIDTH_W'(1);
                        w_cal_lat_nxt = w_cal_sel;
                        w_state_nxt   = (w_cal_sel <= WIDTH_W'(1)) ? QUALIFIED : MEASURE;
                    end
                end
                MEASURE: begin
                    if (r_sync2) begin
                        if (r_width != WIDTH_W'(WIDTH_MAX)) begin
                            w_width_nxt = r_width + WIDTH_W'(1);
                        end
                        if (w_width_nxt >= r_cal_lat) begin
                            w_state_nxt = QUALIFIED;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                QUALIFIED: begin
                    if (r_sync2) begin
                        if (r_width != WIDTH_W'(WIDTH_MAX)) begin
                            w_width_nxt = r_width + WIDTH_W'(1);
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_fish      = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Clear overrides a coincident count event, but the event pulse is still issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_evt  <= 1'b0;
            r_busy <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_evt  <= w_fish;
            r_busy <= (w_state_nxt != IDLE);
            if (clear) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_fish) begin
                if (r_cnt == {CNT_W{1'b1}}) begin
                    r_sat <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign fish_cnt = r_cnt;
    assign fish_evt = r_evt;
    assign busy     = r_busy;
    assign sat      = r_sat;

endmodule

// File: tb/tb_fish_detect.sv
// Self-checking bench for fish_detect: directed vector table, corner sequences and randomized run vs. a tick-level model.
module tb_fish_detect;

    localparam int unsigned CW = 4;
    localparam int unsigned TD = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          sensor   = 1'b0;
    logic [3:0]    fish_cal = 4'd5;
    logic          clear    = 1'b0;
    logic [CW-1:0] fish_cnt;
    logic          fish_evt;
    logic          busy;
    logic          sat;

    always #5 clk = ~clk;

    fish_detect #(
        .CNT_W    (CW),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sensor   (sensor),
        .fish_cal (fish_cal),
        .clear    (clear),
        .fish_cnt (fish_cnt),
        .fish_evt (fish_evt),
        .busy     (busy),
        .sat      (sat)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, sensor history, consecutive blocked ticks.
    int n;
    bit h1, h2;
    int run;
    int cal_l;
    int m_cnt;
    bit m_evt;
    bit m_sat;

    typedef struct {
        bit       sens;
        bit [3:0] cal;
        int       cyc;
        int       exp_cnt;
        bit       exp_busy;
    } vec_t;

    vec_t vecs[14];

    function automatic bit tick_at(input int e);
        return (e > int'(TD)) && (((e - 1) % int'(TD)) == 0);
    endfunction

    task automatic model_reset();
        n = 0; h1 = 0; h2 = 0; run = 0; cal_l = 0;
        m_cnt = 0; m_evt = 0; m_sat = 0;
    endtask

    task automatic model_edge();
        bit s;
        bit fish;
        n++;
        s = h2; h2 = h1; h1 = sensor;
        fish = 0;
        if (tick_at(n)) begin
            if (s) begin
                if (run == 0) cal_l = (fish_cal == 4'd0) ? 1 : int'(fish_cal);
                if (run < 15) run++;
            end else begin
                if (run > 0 && run >= cal_l) fish = 1;
                run = 0;
            end
        end
        m_evt = fish;
        if (clear) begin
            m_cnt = 0;
            m_sat = 0;
        end else if (fish) begin
            if (m_cnt == (1 << CW) - 1) m_sat = 1;
            else m_cnt++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt", int'(fish_cnt), m_cnt);
        check("evt", int'(fish_evt), int'(m_evt));
        check("busy", int'(busy), (run > 0) ? 1 : 0);
        check("sat", int'(sat), int'(m_sat));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_cnt", int'(fish_cnt), 0);
        check("rst_evt", int'(fish_evt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sat", int'(sat), 0);
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic one_fish();
        sensor = 1'b1; fish_cal = 4'd1;
        repeat (8) step();
        sensor = 1'b0;
        repeat (16) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int hold;

        vecs[0]  = '{1'b0, 4'd5,  16, 0, 1'b0};
        vecs[1]  = '{1'b1, 4'd5,  24, 0, 1'b1};
        vecs[2]  = '{1'b0, 4'd5,  16, 1, 1'b0};
        vecs[3]  = '{1'b1, 4'd5,  16, 1, 1'b1};
        vecs[4]  = '{1'b0, 4'd5,  16, 1, 1'b0};
        vecs[5]  = '{1'b1, 4'd5,   8, 1, 1'b1};
        vecs[6]  = '{1'b1, 4'd15, 16, 1, 1'b1};
        vecs[7]  = '{1'b0, 4'd15, 16, 2, 1'b0};
        vecs[8]  = '{1'b1, 4'd1,   8, 2, 1'b1};
        vecs[9]  = '{1'b0, 4'd1,  16, 3, 1'b0};
        vecs[10] = '{1'b1, 4'd0,   8, 3, 1'b1};
        vecs[11] = '{1'b0, 4'd0,  16, 4, 1'b0};
        vecs[12] = '{1'b1, 4'd5,  20, 4, 1'b1};
        vecs[13] = '{1'b0, 4'd5,  16, 5, 1'b0};

        #2;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            sensor   = vecs[i].sens;
            fish_cal = vecs[i].cal;
            repeat (vecs[i].cyc) step();
            check($sformatf("vec%0d_cnt", i), int'(fish_cnt), vecs[i].exp_cnt);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
        end

        // Saturation: count reaches 15, the next fish sets sat, then clear.
        for (int i = 0; i < 10; i++) one_fish();
        check("sat_cnt15", int'(fish_cnt), 15);
        check("sat_pre", int'(sat), 0);
        one_fish();
        check("sat_cnt_hold", int'(fish_cnt), 15);
        check("sat_set", int'(sat), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_cnt", int'(fish_cnt), 0);
        check("clr_sat", int'(sat), 0);

        // Clear on the same edge as a count event.
        one_fish();
        check("pre_coinc_cnt", int'(fish_cnt), 1);
        sensor = 1'b1; fish_cal = 4'd1;
        repeat (8) step();
        sensor = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tick_at(n + 1) && !h2 && run > 0 && run >= cal_l) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                check("coinc_cnt", int'(fish_cnt), 0);
                check("coinc_evt", int'(fish_evt), 1);
                found = 1;
            end else begin
                step();
            end
        end
        if (!found) check("coinc_timeout", 0, 1);
        repeat (8) step();

        // Reset while qualified discards the fish.
        sensor = 1'b1; fish_cal = 4'd1;
        repeat (12) step();
        check("q_busy", int'(busy), 1);
        sensor = 1'b0;
        do_reset();
        repeat (24) step();
        check("post_rst_cnt", int'(fish_cnt), 0);
        check("post_rst_busy", int'(busy), 0);

        // Randomized run against the model.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) do_reset();
            if (hold == 0) begin
                sensor = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 40));
            end
            hold--;
            if ($urandom_range(0, 15) == 0) fish_cal = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 63) == 0);
            step();
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
